// File: rtl/controller_sequencer.sv
// Bus-master sequencer: a six-state one-hot ring (T1..T6) and an opcode decoder
// that produce the load/send strobes for the shared 8-bit bus.
module controller_sequencer (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_enable,
   input  logic [3:0] i_instruction,
   output logic [5:0] o_t_state,
   output logic       o_halt,
   output logic       o_pc_increment,
   output logic       o_pc_send,
   output logic       o_mar_load,
   output logic       o_ram_send,
   output logic       o_ir_load,
   output logic       o_ir_send,
   output logic       o_a_load,
   output logic       o_a_send,
   output logic       o_b_load,
   output logic       o_alu_subtract,
   output logic       o_alu_send,
   output logic       o_out_load
);

   localparam logic [3:0] OPCODE_LDA = 4'h0;
   localparam logic [3:0] OPCODE_ADD = 4'h1;
   localparam logic [3:0] OPCODE_SUB = 4'h2;
   localparam logic [3:0] OPCODE_OUT = 4'hE;
   localparam logic [3:0] OPCODE_HLT = 4'hF;

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } ring_e;

   ring_e ring_q, ring_d;
   logic  halt_q, halt_d;
   logic  active;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         ring_q <= T1;
         halt_q <= 1'b0;
      end else begin
         ring_q <= ring_d;
         halt_q <= halt_d;
      end
   end

   always_comb begin
      ring_d = ring_q;
      halt_d = halt_q;
      if (i_enable && !halt_q) begin
         // HLT parks the ring at T4; only reset leaves this condition.
         if (ring_q == T4 && i_instruction == OPCODE_HLT) begin
            halt_d = 1'b1;
         end else begin
            case (ring_q)
               T1:      ring_d = T2;
               T2:      ring_d = T3;
               T3:      ring_d = T4;
               T4:      ring_d = T5;
               T5:      ring_d = T6;
               T6:      ring_d = T1;
               default: ring_d = T1;
            endcase
         end
      end
   end

   assign active = i_reset_n & i_enable & ~halt_q;

   always_comb begin
      o_pc_increment = 1'b0;
      o_pc_send      = 1'b0;
      o_mar_load     = 1'b0;
      o_ram_send     = 1'b0;
      o_ir_load      = 1'b0;
      o_ir_send      = 1'b0;
      o_a_load       = 1'b0;
      o_a_send       = 1'b0;
      o_b_load       = 1'b0;
      o_alu_subtract = 1'b0;
      o_alu_send     = 1'b0;
      o_out_load     = 1'b0;
      if (active) begin
         case (ring_q)
            T1: begin
               o_pc_send  = 1'b1;
               o_mar_load = 1'b1;
            end
            T2: o_pc_increment = 1'b1;
            T3: begin
               o_ram_send = 1'b1;
               o_ir_load  = 1'b1;
            end
            T4: begin
               if (i_instruction == OPCODE_LDA || i_instruction == OPCODE_ADD ||
                   i_instruction == OPCODE_SUB) begin
                  o_ir_send  = 1'b1;
                  o_mar_load = 1'b1;
               end else if (i_instruction == OPCODE_OUT) begin
                  o_a_send   = 1'b1;
                  o_out_load = 1'b1;
               end
            end
            T5: begin
               if (i_instruction == OPCODE_LDA) begin
                  o_ram_send = 1'b1;
                  o_a_load   = 1'b1;
               end else if (i_instruction == OPCODE_ADD || i_instruction == OPCODE_SUB) begin
                  o_ram_send     = 1'b1;
                  o_b_load       = 1'b1;
                  o_alu_subtract = (i_instruction == OPCODE_SUB);
               end
            end
            T6: begin
               if (i_instruction == OPCODE_ADD || i_instruction == OPCODE_SUB) begin
                  o_alu_send     = 1'b1;
                  o_a_load       = 1'b1;
                  o_alu_subtract = (i_instruction == OPCODE_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_t_state = ring_q;
   assign o_halt    = halt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed and random stimulus for controller_sequencer; a behavioural model
// feeds an expected queue that is checked once per cycle.
module tb_controller_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] instr;
   logic [5:0] t_state;
   logic       halt;
   logic pc_inc, pc_send, mar_load, ram_send, ir_load, ir_send;
   logic a_load, a_send, b_load, alu_sub, alu_send, out_load;

   int total = 0;
   int bad   = 0;
   int pc_inc_count = 0;

   // model state: m_t is 0..5 for T1..T6
   int   m_t;
   logic m_h;

   logic [18:0] exp_q[$];

   always #5 clk = ~clk;

   controller_sequencer dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_instruction(instr),
      .o_t_state(t_state), .o_halt(halt),
      .o_pc_increment(pc_inc), .o_pc_send(pc_send), .o_mar_load(mar_load),
      .o_ram_send(ram_send), .o_ir_load(ir_load), .o_ir_send(ir_send),
      .o_a_load(a_load), .o_a_send(a_send), .o_b_load(b_load),
      .o_alu_subtract(alu_sub), .o_alu_send(alu_send), .o_out_load(out_load)
   );

   // strobe bits: 11 pc_inc 10 pc_send 9 mar_load 8 ram_send 7 ir_load 6 ir_send
   //              5 a_load 4 a_send 3 b_load 2 alu_sub 1 alu_send 0 out_load
   function automatic logic [11:0] model_strobes(int t, logic h, logic [3:0] op,
                                                 logic e, logic rn);
      logic [11:0] s;
      s = '0;
      if (rn && e && !h) begin
         if (t == 0) begin s[10] = 1; s[9] = 1; end
         if (t == 1) s[11] = 1;
         if (t == 2) begin s[8] = 1; s[7] = 1; end
         if (t == 3 && (op == 4'h0 || op == 4'h1 || op == 4'h2)) begin s[6] = 1; s[9] = 1; end
         if (t == 3 && op == 4'hE) begin s[4] = 1; s[0] = 1; end
         if (t == 4 && op == 4'h0) begin s[8] = 1; s[5] = 1; end
         if (t == 4 && (op == 4'h1 || op == 4'h2)) begin s[8] = 1; s[3] = 1; end
         if (t == 5 && (op == 4'h1 || op == 4'h2)) begin s[1] = 1; s[5] = 1; end
         if ((t == 4 || t == 5) && op == 4'h2) s[2] = 1;
      end
      return s;
   endfunction

   task automatic step(input logic rn, input logic e, input logic [3:0] op, input string tag);
      logic [18:0] exp_v, obs_v;
      logic [4:0]  sends;
      @(negedge clk);
      rst_n = rn;
      en    = e;
      instr = op;
      #1;
      exp_q.push_back({6'(1 << m_t), m_h, model_strobes(m_t, m_h, op, e, rn)});
      obs_v = {t_state, halt, pc_inc, pc_send, mar_load, ram_send, ir_load, ir_send,
               a_load, a_send, b_load, alu_sub, alu_send, out_load};
      exp_v = exp_q.pop_front();
      total++;
      assert (obs_v === exp_v) else begin
         bad++;
         $error("FAIL %s: observed t/h/strobes=%h/%b/%b expected %h/%b/%b", tag,
                obs_v[18:13], obs_v[12], obs_v[11:0], exp_v[18:13], exp_v[12], exp_v[11:0]);
      end
      sends = {pc_send, ram_send, ir_send, a_send, alu_send};
      total++;
      assert ($countones(sends) <= 1) else begin
         bad++;
         $error("FAIL bus_excl %s: observed sends=%b expected at most one set", tag, sends);
      end
      if (pc_inc === 1'b1) pc_inc_count++;
      // model advances on the coming posedge
      if (!rn) begin
         m_t = 0;
         m_h = 1'b0;
      end else if (e && !m_h) begin
         if (m_t == 3 && op == 4'hF) m_h = 1'b1;
         else m_t = (m_t + 1) % 6;
      end
   endtask

   initial begin
      logic [3:0] op_tab [6];
      logic [3:0] rop;
      op_tab[0] = 4'h0; op_tab[1] = 4'h1; op_tab[2] = 4'h2;
      op_tab[3] = 4'hE; op_tab[4] = 4'h5; op_tab[5] = 4'hF;

      rst_n = 1'b0;
      en    = 1'b0;
      instr = 4'h0;
      m_t   = 0;
      m_h   = 1'b0;

      // reset held: state T1 and all strobes masked
      step(1'b0, 1'b1, 4'h0, "reset0");
      step(1'b0, 1'b1, 4'h0, "reset1");

      // LDA twice through the ring
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 4'h0, "lda");

      // SUB
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'h2, "sub");

      // OUT then NOP
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'hE, "out");
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'h5, "nop");

      // HLT: fetch, T4 silent, then parked at T4
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'hF, "hlt_run");
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 4'hF, "halted");
      step(1'b0, 1'b1, 4'hF, "hlt_reset");
      step(1'b1, 1'b0, 4'h0, "after_reset");

      // enable gap during T2: pc_increment once only
      pc_inc_count = 0;
      step(1'b1, 1'b1, 4'h0, "gap_t1");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, "gap_t2_off");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'h0, "gap_rest");
      total++;
      assert (pc_inc_count == 1) else begin
         bad++;
         $error("FAIL pc_inc_once: observed %0d pulses expected 1", pc_inc_count);
      end

      // ADD with reset at T5
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'h1, "add_pre");
      step(1'b0, 1'b1, 4'h1, "add_t5_reset");
      step(1'b1, 1'b1, 4'h1, "add_after_reset");

      // random opcodes and enable
      for (int i = 0; i < 1000; i++) begin
         rop = (i % 3 == 0) ? 4'($urandom_range(0, 15)) : op_tab[$urandom_range(0, 5)];
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), rop, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
